// File: rtl/mem_pkg.sv
// Packet-memory block geometry shared by the rx and tx MAC paths.
package mem_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BYTES_W     = $clog2(BLOCK_BYTES) + 1;

    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

endpackage

// File: rtl/rx_tx_pkg.sv
// Framing constants and rx FSM encoding for the MAC datapaths.
package rx_tx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [2:0]  MAX_PREAMBLE  = 3'd7;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_t;

    // Residue is given MSB-first; the reflected CRC register holds it reversed.
    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_block_assembler_crc32_d8.sv
// Combinational reflected CRC-32 (poly 0xEDB88320) update for one byte.
module crc32_d8 (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] w_c;

    always_comb begin
        w_c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ 32'hEDB88320) : (w_c >> 1);
        end
        crc_o = w_c;
    end

endmodule

// File: rtl/rx_block_assembler.sv
// Rx framing check and block packer into packet memory.
// Optional FCS residue check is enabled by defining RX_FCS_CHECK_EN.
module rx_block_assembler
    import rx_tx_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int BLOCK_BYTES     = mem_pkg::BLOCK_BYTES,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int LEN_W           = 11
) (
    input  logic                  switch_clk,
    input  logic                  switch_rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  rx_last_i,
    input  logic                  rx_err_i,
    output logic                  rx_ready_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i,
    output logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] mem_block_o,
    output logic                  mem_start_o,
    output logic                  mem_end_o,
    output logic [$clog2(BLOCK_BYTES):0] mem_bytes_o,
    output logic                  mem_err_o,
    output logic                  frame_done_o,
    output logic [LEN_W-1:0]      frame_len_o,
    output logic                  frame_ok_o
);

    localparam int IDX_W   = $clog2(BLOCK_BYTES);
    localparam int BYTES_W = IDX_W + 1;

    typedef logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] blk_t;

    typedef struct packed {
        blk_t               data;
        logic               first;
        logic               last;
        logic [BYTES_W-1:0] bytes;
        logic               err;
        logic [LEN_W-1:0]   len;
    } desc_t;

    rx_state_t        r_state;
    logic [2:0]       r_pre_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic             r_first;
    blk_t             r_fill;
    logic             r_out_v;
    desc_t            r_out;
    logic             r_pend_v;
    desc_t            r_pend;
    logic             r_done;
    logic [LEN_W-1:0] r_done_len;
    logic             r_done_ok;

    logic             w_acc_in;
    logic             w_acc_out;
    logic             w_out_free;
    logic             w_in_data;
    logic [LEN_W-1:0] w_len_nx;
    logic             w_over;
    logic             w_end;
    logic             w_close;
    logic             w_fcs_bad;
    logic             w_is_pre;
    logic             w_is_sfd;
    blk_t             w_fill_nx;
    desc_t            w_desc;

    assign w_acc_in   = rx_valid_i & ~r_pend_v;
    assign w_acc_out  = r_out_v & mem_ready_i;
    assign w_out_free = ~r_out_v | mem_ready_i;
    assign w_in_data  = w_acc_in & (r_state == ST_DATA);
    assign w_is_pre   = (rx_data_i == PREAMBLE_BYTE);
    assign w_is_sfd   = (rx_data_i == SFD_BYTE);
    assign w_len_nx   = r_len + LEN_W'(1);
    assign w_over     = (w_len_nx == LEN_W'(MAX_FRAME_BYTES + 1));
    assign w_end      = rx_last_i | rx_err_i | w_over;
    assign w_close    = w_in_data &
                        (w_end | (r_idx == IDX_W'(BLOCK_BYTES - 1)));

`ifdef RX_FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_nx;

    crc32_d8 u_crc (
        .crc_i  (r_crc),
        .data_i (rx_data_i),
        .crc_o  (w_crc_nx)
    );

    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            r_crc <= '1;
        end else if (r_state != ST_DATA) begin
            r_crc <= '1;
        end else if (w_in_data) begin
            r_crc <= w_crc_nx;
        end
    end

    assign w_fcs_bad = (bitrev32(w_crc_nx) != CRC_RESIDUE);
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_comb begin
        w_fill_nx        = r_fill;
        w_fill_nx[r_idx] = rx_data_i;
    end

    always_comb begin
        w_desc       = '0;
        w_desc.data  = w_fill_nx;
        w_desc.first = r_first;
        w_desc.last  = w_end;
        w_desc.bytes = {1'b0, r_idx} + BYTES_W'(1);
        w_desc.len   = w_len_nx;
        w_desc.err   = rx_err_i | w_over |
                       (rx_last_i & (w_len_nx < LEN_W'(MIN_FRAME_BYTES))) |
                       (rx_last_i & w_fcs_bad);
    end

    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_first   <= 1'b0;
            r_fill    <= '0;
        end else if (w_acc_in) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_is_pre && !rx_err_i && !rx_last_i) begin
                        r_state   <= ST_PRE;
                        r_pre_cnt <= 3'd1;
                    end else if (!rx_last_i) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_PRE: begin
                    if (rx_err_i || rx_last_i) begin
                        r_state <= rx_last_i ? ST_IDLE : ST_DROP;
                    end else if (w_is_pre && r_pre_cnt != MAX_PREAMBLE) begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                    end else if (w_is_sfd) begin
                        r_state <= ST_DATA;
                        r_idx   <= '0;
                        r_len   <= '0;
                        r_first <= 1'b1;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    r_fill <= w_fill_nx;
                    r_len  <= w_len_nx;
                    if (w_close) begin
                        r_idx   <= '0;
                        r_first <= 1'b0;
                        if (w_end) begin
                            r_state <= rx_last_i ? ST_IDLE : ST_DROP;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DROP: begin
                    if (rx_last_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pending slot only fills while the output is stalled; it drains first.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            r_out_v    <= 1'b0;
            r_out      <= '0;
            r_pend_v   <= 1'b0;
            r_pend     <= '0;
            r_done     <= 1'b0;
            r_done_len <= '0;
            r_done_ok  <= 1'b0;
        end else begin
            if (r_pend_v) begin
                if (w_out_free) begin
                    r_out_v  <= 1'b1;
                    r_out    <= r_pend;
                    r_pend_v <= 1'b0;
                end
            end else if (w_close) begin
                if (w_out_free) begin
                    r_out_v <= 1'b1;
                    r_out   <= w_desc;
                end else begin
                    r_pend_v <= 1'b1;
                    r_pend   <= w_desc;
                end
            end else if (w_acc_out) begin
                r_out_v <= 1'b0;
            end
            r_done <= w_acc_out & r_out.last;
            if (w_acc_out && r_out.last) begin
                r_done_len <= r_out.len;
                r_done_ok  <= ~r_out.err;
            end
        end
    end

    assign rx_ready_o   = ~r_pend_v;
    assign mem_we_o     = r_out_v;
    assign mem_block_o  = r_out.data;
    assign mem_start_o  = r_out.first;
    assign mem_end_o    = r_out.last;
    assign mem_bytes_o  = r_out.bytes;
    assign mem_err_o    = r_out.err & r_out.last;
    assign frame_done_o = r_done;
    assign frame_len_o  = r_done_len;
    assign frame_ok_o   = r_done_ok;

endmodule

// File: doc/rx_block_assembler.md
Name: rx_block_assembler

Overview:
Receive-side counterpart of the transmit MAC control path, clocked in the switch domain. It takes the received byte stream after the GMII-to-switch clock-domain crossing and checks and strips the preamble and SFD. It packs the payload into BLOCK_BYTES-wide blocks and writes each block to packet memory with a valid/ready handshake. It emits one status pulse per frame for the lookup/VOQ enqueue logic, and flags runt, oversize and errored frames on the final block.

Parameters:
DATA_WIDTH, 8, byte width of the rx stream
BLOCK_BYTES, 64, bytes per memory block
MIN_FRAME_BYTES, 64, minimum legal payload length (excluding preamble/SFD, including FCS)
MAX_FRAME_BYTES, 1518, maximum legal payload length
LEN_W, 11, width of the frame length counter

Ports:
switch_clk  in  1  switch clock
switch_rst_n  in  1  reset, asynchronous, active-low
rx_data_i  in  DATA_WIDTH  received byte
rx_valid_i  in  1  byte valid
rx_last_i  in  1  last byte of frame (qualified by rx_valid_i)
rx_err_i  in  1  PHY error on this byte (qualified by rx_valid_i)
rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o
mem_we_o  out  1  block write request
mem_ready_i  in  1  memory accepts block when mem_we_o && mem_ready_i
mem_block_o  out  BLOCK_BYTES x DATA_WIDTH  block data, byte 0 first on wire
mem_start_o  out  1  block is first of frame
mem_end_o  out  1  block is last of frame
mem_bytes_o  out  $clog2(BLOCK_BYTES)+1  valid bytes in block, 1..BLOCK_BYTES
mem_err_o  out  1  frame bad; valid only with mem_end_o
frame_done_o  out  1  one-cycle pulse after the final block is accepted
frame_len_o  out  LEN_W  payload length, valid with frame_done_o (saturates at MAX_FRAME_BYTES+1)
frame_ok_o  out  1  frame good, valid with frame_done_o

Behaviour:
- Reset (async, active-low): every output is 0 except rx_ready_o=1. The FSM goes to IDLE, counters clear, and any partial frame is discarded. After reset, no block write is issued for the interrupted frame.
- FSM states and transitions:
  - IDLE: byte 0x55 -> PRE. Any other byte -> DROP, unless it carries rx_last_i, in which case stay in IDLE.
  - PRE: 0x55 -> stay, up to 7 in total; an 8th 0x55 -> DROP. 0xD5 -> DATA. Any other byte -> DROP.
  - DATA: described below.
  - DROP: consume bytes until rx_last_i, then IDLE. No memory traffic and no status pulse.
  - A frame that fails in IDLE/PRE produces no memory writes.
- DATA, normal filling: each accepted byte goes to fill[idx]; idx and len increment.
- DATA, block close: the fill block closes when idx reaches BLOCK_BYTES-1, on rx_last_i, on rx_err_i, or when len reaches MAX_FRAME_BYTES+1.
  - A close raised by rx_err_i or oversize (without rx_last_i) sets end=1, err=1, then goes to DROP.
  - A close raised by rx_last_i sets end=1. err = rx_err_i | (len < MIN_FRAME_BYTES) | oversize. The FSM then returns to IDLE.
  - rx_err_i together with rx_last_i closes with err and goes straight to IDLE.
- Buffering: a fill buffer plus an output register.
  - A closed fill moves to the output register in the same cycle when the output is empty or being accepted that cycle; otherwise it is held as pending.
  - rx_ready_o = !pending.
  - Fully back-to-back blocks and frames are supported with zero bubbles when mem_ready_i stays high.
- Memory handshake: mem_we_o rises the cycle after close. All mem_* outputs stay stable while mem_we_o && !mem_ready_i; mem_we_o drops after acceptance unless the next block is loaded.
- Frame flags: mem_start_o=1 on the first block of each frame only. A one-block frame has mem_start_o=mem_end_o=1.
- Frame status: frame_done_o pulses the cycle after the end block is accepted. frame_ok_o = !err.
- A new frame's preamble may be accepted while the previous end block is still pending in the output register.

Optional Feature:
RX_FCS_CHECK_EN
- Defined: a CRC-32 (reflected, init 0xFFFFFFFF) runs over every DATA byte, including the FCS. At rx_last_i the residue must equal 0xC704DD7B, otherwise err=1. The CRC adds no latency.
- Undefined: no CRC logic; err comes only from rx_err_i and the length checks.

Decomposition:
- rx_tx_pkg: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, MAX_PREAMBLE=7, CRC_RESIDUE, and the rx FSM state enum (IDLE, PRE, DATA, DROP).
- mem_pkg: BLOCK_BYTES and the block typedef (BLOCK_BYTES x 8 packed array) shared with tx_mac_control.
- Sub-module: crc32_d8, a combinational next-CRC for one byte, instantiated only under RX_FCS_CHECK_EN.

Test Plan:
- 7x55, D5, bytes 0x00..0x3F, last on 0x3F, mem_ready_i=1 -> one write with start=1, end=1, bytes=64, err=0, block[i]=i; frame_done_o with len=64, ok=1.
- 150-byte frame with bytes i&0xFF -> three writes with bytes=64/64/22; start only on the first, end only on the third; frame_len_o=150.
- 150-byte frame with mem_ready_i low for 20 cycles at block 1 -> rx_ready_o drops, the block stays stable, data is intact, no byte is lost.
- 40-byte frame -> one write, bytes=40, end=1, err=1; frame_ok_o=0. A 1600-byte frame -> err end block at len 1519, then DROP to rx_last, frame_len_o=1519.
- Preamble 55 55 0xAA... -> no mem_we_o, no frame_done_o. An immediately following good 64-byte frame -> normal.
- Assert switch_rst_n=0 mid-block 2 of a 500-byte frame -> outputs reset at once. After release, a 64-byte frame passes cleanly.
